sr_latch_driver: RTL and testbench
==================================

# sr_latch_driver

Command-side driver for the team's SR latch cell. Accepts a requested output level over a valid/ready handshake and generates the en/S/R pulse sequence that moves the latch to that level, with programmable pulse width and settle time. It never issues the illegal S=R=1 code and keeps a registered model of the latch state, so redundant requests produce no pulse. Sits between control logic and any SRlatch instance, driving its en, S and R inputs.

## Interface
- PULSE_CYCLES, 2: cycles en plus S or R are held high; legal range 1..255.
- SETTLE_CYCLES, 1: idle cycles after the pulse before completion; legal range 0..255. 0 skips the SETTLE state.
- clk  input  1  rising-edge clock.
- rst  input  1  reset: asynchronous, active-high.
- req_valid  input  1  request present.
- req_level  input  1  requested latch level; 1 = set, 0 = clear.
- req_ready  output  1  high only in IDLE.
- lat_en  output  1  latch enable; registered.
- lat_s  output  1  set command; registered.
- lat_r  output  1  reset command; registered.
- q_model  output  1  tracked latch level; registered.
- done  output  1  one-cycle completion pulse.
- busy  output  1  high in any state other than IDLE.

## Operation
- States: IDLE, PULSE, SETTLE, DONE.
- IDLE
  - req_ready=1; all command outputs 0.
  - Accept when req_valid&&req_ready; capture req_level.
  - If req_level==q_model, go to DONE with no pulse.
  - Otherwise go to PULSE and load the counter with PULSE_CYCLES-1.
- PULSE
  - lat_en=1.
  - For a set: lat_s=1, lat_r=0. For a clear: lat_s=0, lat_r=1.
  - Counter decrements each cycle. At 0, q_model takes the captured level; go to SETTLE, or to DONE if SETTLE_CYCLES=0.
- SETTLE: lat_en=lat_s=lat_r=0 for SETTLE_CYCLES cycles, then DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- req_level and req_valid are ignored outside IDLE; there is no queueing.
- Invariants, checked by assertion:
  - lat_s&lat_r is never 1.
  - lat_s or lat_r is high only while lat_en=1.
  - done is never high for two consecutive cycles.

## Timing
- Reset asserted, asynchronously:
  - state=IDLE; lat_en=lat_s=lat_r=0; q_model=0 (matches latch reset value); done=0; busy=0; req_ready=1.
  - A reset mid-PULSE drops lat_en/lat_s/lat_r immediately and abandons the request; no done is produced.
- Accept at edge t:
  - Pulse outputs high for cycles t+1 .. t+P.
  - q_model changes at edge t+P.
  - SETTLE occupies t+P+1 .. t+P+S.
  - done is high in cycle t+P+S+1.
  - req_ready is high again in cycle t+P+S+2.
- Redundant request accepted at edge t: done in cycle t+1; req_ready high again in cycle t+2.
- Throughput is one request per P+S+2 cycles (2 cycles if redundant). Back-to-back acceptance is possible the first cycle req_ready returns.
- Counter width is 8 bits; no wrap, since it loads only from the parameters. Parameters outside the legal range are a compile-time error.

## Structure
- Package sr_pkg holds:
  - State enum sr_drv_state_t (IDLE, PULSE, SETTLE, DONE).
  - Command constants SR_HOLD=2'b00, SR_CLR=2'b01, SR_SET=2'b10, SR_ILLEGAL=2'b11, matching the latch's {S,R} decode.
- One sub-module, sr_pulse_timer: loadable down-counter with a zero flag, used for both the PULSE and SETTLE phases.
- The FSM and output registers stay in sr_latch_driver.
- The bench instantiates a real SRlatch on lat_en/lat_s/lat_r with rst shared, and checks latch Q against q_model every cycle after DONE.

## Test plan
- Reset release, then req_valid=1, req_level=1 at edge 0 (P=2, S=1) -> lat_en=lat_s=1 in cycles 1-2; q_model=1 from edge 2; done in cycle 4; latch Q=1; req_ready high in cycle 5.
- q_model=1, then request level 0 -> lat_r pulses for 2 cycles with lat_s=0 throughout; latch Q=0; q_model=0.
- q_model=0, then request level 0 -> no lat_en activity; done in cycle 1 after accept; req_ready high in cycle 2.
- Assert rst in the second PULSE cycle of a set -> lat_en/lat_s fall in the same cycle; q_model=0; no done; the next request is accepted normally.
- Hold req_valid=1 continuously with alternating req_level, using P=1, S=0 -> accepts every 3 cycles; lat_s and lat_r strictly alternate; never both 1.
- Toggle req_level while busy -> ignored; completion reflects the captured level only.

Source files
------------

// File: rtl/sr_pkg.sv
// Shared types and command encodings for the SR latch driver.
// {S,R} command codes follow the latch cell's own decode.
package sr_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PULSE  = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } sr_drv_state_t;

  localparam logic [1:0] SR_HOLD    = 2'b00;
  localparam logic [1:0] SR_CLR     = 2'b01;
  localparam logic [1:0] SR_SET     = 2'b10;
  localparam logic [1:0] SR_ILLEGAL = 2'b11;

  localparam int SR_CNT_W = 8;

  function automatic logic [1:0] sr_cmd(input logic level);
    return level ? SR_SET : SR_CLR;
  endfunction
endpackage

// File: rtl/SRlatch.sv
// Behavioural model of the SR latch cell: level-sensitive, gated by en,
// async clear on rst. S=R=1 holds rather than resolving.
module SRlatch (
  input  logic rst,
  input  logic en,
  input  logic s,
  input  logic r,
  output logic q
);
  always_latch begin
    if (rst)                  q <= 1'b0;
    else if (en && (s ^ r))   q <= s;
  end
endmodule

// File: rtl/sr_pulse_timer.sv
// Loadable down-counter with a zero flag; times both the pulse and settle phases.
module sr_pulse_timer
  import sr_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                dec,
  input  logic [SR_CNT_W-1:0] load_val,
  output logic                zero
);
  logic [SR_CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   cnt <= '0;
    else if (load)             cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/sr_latch_driver.sv
// Drives en/S/R of an SR latch cell to reach a requested level, tracking
// the latch state so that requests for the current level skip the pulse.
module sr_latch_driver
  import sr_pkg::*;
#(
  parameter int PULSE_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic req_level,
  output logic req_ready,
  output logic lat_en,
  output logic lat_s,
  output logic lat_r,
  output logic q_model,
  output logic done,
  output logic busy
);
  generate
    if (PULSE_CYCLES < 1 || PULSE_CYCLES > 255) begin : g_bad_pulse
      $error("sr_latch_driver: PULSE_CYCLES must be 1..255");
    end
    if (SETTLE_CYCLES < 0 || SETTLE_CYCLES > 255) begin : g_bad_settle
      $error("sr_latch_driver: SETTLE_CYCLES must be 0..255");
    end
  endgenerate

  localparam logic [SR_CNT_W-1:0] P_LOAD = SR_CNT_W'(PULSE_CYCLES - 1);
  localparam logic [SR_CNT_W-1:0] S_LOAD =
    (SETTLE_CYCLES == 0) ? '0 : SR_CNT_W'(SETTLE_CYCLES - 1);

  sr_drv_state_t       state;
  logic                level_q;
  logic                accept;
  logic                tmr_load;
  logic                tmr_dec;
  logic [SR_CNT_W-1:0] tmr_val;
  logic                tmr_zero;

  assign accept    = req_valid && (state == IDLE);
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (accept && req_level != q_model) begin
      tmr_load = 1'b1;
      tmr_val  = P_LOAD;
    end else if (state == PULSE && tmr_zero && SETTLE_CYCLES != 0) begin
      tmr_load = 1'b1;
      tmr_val  = S_LOAD;
    end
  end

  assign tmr_dec = (state == PULSE) || (state == SETTLE);

  sr_pulse_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Command outputs are set/cleared on the same edge as the state change so
  // the latch sees clean, glitch-free registered levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      level_q        <= 1'b0;
      q_model        <= 1'b0;
      lat_en         <= 1'b0;
      {lat_s, lat_r} <= SR_HOLD;
    end else begin
      case (state)
        IDLE: if (accept) begin
          level_q <= req_level;
          if (req_level == q_model) begin
            state <= DONE;
          end else begin
            state          <= PULSE;
            lat_en         <= 1'b1;
            {lat_s, lat_r} <= sr_cmd(req_level);
          end
        end
        PULSE: if (tmr_zero) begin
          q_model        <= level_q;
          lat_en         <= 1'b0;
          {lat_s, lat_r} <= SR_HOLD;
          state          <= (SETTLE_CYCLES == 0) ? DONE : SETTLE;
        end
        SETTLE: if (tmr_zero) state <= DONE;
        DONE:   state <= IDLE;
        default: begin
          state          <= IDLE;
          lat_en         <= 1'b0;
          {lat_s, lat_r} <= SR_HOLD;
        end
      endcase
    end
  end

  a_no_illegal: assert property (@(posedge clk) disable iff (rst)
    {lat_s, lat_r} != SR_ILLEGAL);
  a_cmd_needs_en: assert property (@(posedge clk) disable iff (rst)
    (lat_s || lat_r) |-> lat_en);
  a_done_single: assert property (@(posedge clk) disable iff (rst)
    done |=> !done);
endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver driving a real SRlatch, plus a
// second P=1/S=0 instance for the back-to-back throughput case.
module tb_sr_latch_driver;
  logic clk = 1'b0;
  logic rst;
  logic req_valid, req_level;
  logic req_ready, lat_en, lat_s, lat_r, q_model, done, busy;
  logic latch_q;
  logic req_valid2, req_level2;
  logic req_ready2, lat_en2, lat_s2, lat_r2, q_model2, done2, busy2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sr_latch_driver #(.PULSE_CYCLES(2), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_level(req_level),
    .req_ready(req_ready), .lat_en(lat_en), .lat_s(lat_s), .lat_r(lat_r),
    .q_model(q_model), .done(done), .busy(busy)
  );

  SRlatch u_latch (.rst(rst), .en(lat_en), .s(lat_s), .r(lat_r), .q(latch_q));

  sr_latch_driver #(.PULSE_CYCLES(1), .SETTLE_CYCLES(0)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_level(req_level2),
    .req_ready(req_ready2), .lat_en(lat_en2), .lat_s(lat_s2), .lat_r(lat_r2),
    .q_model(q_model2), .done(done2), .busy(busy2)
  );

  // Observed output vector: {lat_en, lat_s, lat_r, q_model, done, busy, req_ready}
  logic [6:0] obs;
  assign obs = {lat_en, lat_s, lat_r, q_model, done, busy, req_ready};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_level = 1'b0;
    req_valid2 = 1'b0; req_level2 = 1'b0;
    #3;
    checks++;
    if (obs !== 7'b0000001) begin
      errors++; $display("FAIL reset_outputs: got %b want %b", obs, 7'b0000001);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if (obs !== 7'b0000001 || latch_q !== 1'b0) begin
      errors++; $display("FAIL reset_release: got %b q=%b want 0000001 q=0", obs, latch_q);
    end
  endtask

  // Accept a set from q_model=0 and follow the P=2,S=1 timeline.
  task automatic test_set(input string name);
    logic [6:0] exp_seq [5];
    exp_seq = '{7'b1100010, 7'b1100010, 7'b0001010, 7'b0001110, 7'b0001001};
    req_valid = 1'b1; req_level = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (obs !== exp_seq[c]) begin
        errors++; $display("FAIL %s cycle%0d: got %b want %b", name, c + 1, obs, exp_seq[c]);
      end
      if (c >= 3) begin
        checks++;
        if (latch_q !== 1'b1) begin
          errors++; $display("FAIL %s latch_q cycle%0d: got %b want 1", name, c + 1, latch_q);
        end
      end
      if (c < 4) tick();
    end
  endtask

  task automatic test_clear();
    logic [6:0] exp_seq [5];
    exp_seq = '{7'b1011010, 7'b1011010, 7'b0000010, 7'b0000110, 7'b0000001};
    req_valid = 1'b1; req_level = 1'b0;
    tick();
    req_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (obs !== exp_seq[c]) begin
        errors++; $display("FAIL clear cycle%0d: got %b want %b", c + 1, obs, exp_seq[c]);
      end
      if (c >= 3) begin
        checks++;
        if (latch_q !== 1'b0) begin
          errors++; $display("FAIL clear latch_q cycle%0d: got %b want 0", c + 1, latch_q);
        end
      end
      if (c < 4) tick();
    end
  endtask

  task automatic test_redundant();
    req_valid = 1'b1; req_level = 1'b0;
    tick();
    req_valid = 1'b0;
    checks++;
    if (obs !== 7'b0000110) begin
      errors++; $display("FAIL redundant cycle1: got %b want %b", obs, 7'b0000110);
    end
    tick();
    checks++;
    if (obs !== 7'b0000001 || latch_q !== 1'b0) begin
      errors++; $display("FAIL redundant cycle2: got %b q=%b want 0000001 q=0", obs, latch_q);
    end
  endtask

  task automatic test_reset_mid_pulse();
    req_valid = 1'b1; req_level = 1'b1;
    tick();
    req_valid = 1'b0;
    checks++;
    if (obs !== 7'b1100010) begin
      errors++; $display("FAIL midrst pulse1: got %b want %b", obs, 7'b1100010);
    end
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== 7'b0000001 || latch_q !== 1'b0) begin
      errors++; $display("FAIL midrst async: got %b q=%b want 0000001 q=0", obs, latch_q);
    end
    #2;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (obs !== 7'b0000001) begin
        errors++; $display("FAIL midrst after%0d: got %b want %b", c, obs, 7'b0000001);
      end
    end
  endtask

  // Toggling req_level while busy must not disturb the captured clear.
  task automatic test_toggle_while_busy();
    logic [6:0] exp_seq [5];
    exp_seq = '{7'b1011010, 7'b1011010, 7'b0000010, 7'b0000110, 7'b0000001};
    req_valid = 1'b1; req_level = 1'b0;
    tick();
    req_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (obs !== exp_seq[c]) begin
        errors++; $display("FAIL toggle cycle%0d: got %b want %b", c + 1, obs, exp_seq[c]);
      end
      req_level = ~req_level;
      if (c < 4) tick();
    end
    checks++;
    if (latch_q !== 1'b0) begin
      errors++; $display("FAIL toggle latch_q: got %b want 0", latch_q);
    end
    req_level = 1'b0;
  endtask

  // P=1,S=0 with req_valid held: accept every 3 cycles, S and R alternate.
  task automatic test_back_to_back();
    logic [4:0] o2;
    logic [4:0] e2;
    req_valid2 = 1'b1; req_level2 = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      o2 = {lat_en2, lat_s2, lat_r2, done2, req_ready2};
      e2 = {(n % 3 == 1),
            (n % 3 == 1) && ((n / 3) % 2 == 0),
            (n % 3 == 1) && ((n / 3) % 2 == 1),
            (n % 3 == 2),
            (n % 3 == 0)};
      checks++;
      if (o2 !== e2) begin
        errors++; $display("FAIL b2b cycle%0d: got %b want %b", n, o2, e2);
      end
      if (n % 3 == 0) req_level2 = ((n / 3) % 2 == 0);
    end
    req_valid2 = 1'b0;
    checks++;
    if (q_model2 !== 1'b0) begin
      errors++; $display("FAIL b2b q_model: got %b want 0", q_model2);
    end
  endtask

  initial begin
    test_reset();
    test_set("set");
    test_clear();
    test_redundant();
    test_reset_mid_pulse();
    test_set("set_after_rst");
    test_toggle_while_busy();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
